// File: rtl/multi_pattern_serializer.sv
// Multi-channel pattern serializer: NUM_PAT writable patterns of programmable length.
// A selected pattern is shifted out MSB-first, either once or repeated back to back.
module multi_pattern_serializer #(
  parameter int               NUM_PAT = 2,
  parameter int               SEL_W   = 1,
  parameter int               PAT_W   = 88,
  parameter int               LEN_W   = 7,
  parameter logic [PAT_W-1:0] RST_PAT = 88'h123456789ABCDEF1234567,
  parameter int               RST_LEN = 88
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [PAT_W-1:0] wr_data,
  input  logic [LEN_W-1:0] wr_len,
  input  logic             start,
  input  logic [SEL_W-1:0] start_sel,
  input  logic             repeat_en,
  input  logic             stop,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] RST_LEN_L = LEN_W'(RST_LEN);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_n;
  logic [PAT_W-1:0]   pat [NUM_PAT];
  logic [LEN_W-1:0]   len [NUM_PAT];
  logic [PAT_W-1:0]   work;
  logic [LEN_W-1:0]   cnt;
  logic [SEL_W-1:0]   ch;
  logic [SEL_W-1:0]   ld_sel;
  logic [LEN_W-1:0]   ld_len;
  logic [LEN_W-1:0]   ld_top;
  logic               sel_ok;
  logic               load;
  logic               advance;
  logic               finish;
  logic               err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // In IDLE the load source is the requested channel; in SHIFT it is the running one (reload).
  always_comb begin
    state_n = state;
    load    = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    err_n   = 1'b0;
    ld_sel  = (state == IDLE) ? start_sel : ch;
    sel_ok  = int'(ld_sel) < NUM_PAT;
    ld_len  = sel_ok ? len[ld_sel] : '0;
    ld_top  = ld_len - 1'b1;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          if (sel_ok && ld_len != '0) begin
            load    = 1'b1;
            state_n = SHIFT;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (stop) begin
          state_n = IDLE;
        end else if (cnt != '0) begin
          advance = 1'b1;
        end else if (repeat_en && ld_len != '0) begin
          load = 1'b1;
        end else begin
          state_n = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Non-blocking update means a same-edge load still sees the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PAT; i++) begin
        pat[i] <= RST_PAT;
        len[i] <= RST_LEN_L;
      end
    end else if (wr_en && int'(wr_sel) < NUM_PAT) begin
      pat[wr_sel] <= wr_data;
      len[wr_sel] <= (wr_len > MAX_LEN) ? MAX_LEN : wr_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work    <= '0;
      cnt     <= '0;
      ch      <= '0;
      ser_out <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= finish;
      err  <= err_n;
      if (load) begin
        ch      <= ld_sel;
        work    <= pat[ld_sel];
        cnt     <= ld_top;
        ser_out <= pat[ld_sel][ld_top];
      end else if (advance) begin
        cnt     <= cnt - 1'b1;
        ser_out <= work[cnt - 1'b1];
      end else begin
        ser_out <= 1'b0;
      end
    end
  end

  assign busy      = (state == SHIFT);
  assign ser_valid = (state == SHIFT);

endmodule
